// File: rtl/wr_stream_packer_pkg.sv
// wr_stream_packer_pkg: shared widths and defaults for the write-side stream packer
package wr_stream_packer_pkg;
  localparam int IN_W_DEF = 2;
  localparam int RATIO_DEF = 4;
  function automatic int out_w(input int in_w, input int ratio);
    return in_w * ratio;
  endfunction
  function automatic int idx_w(input int ratio);
    return $clog2(ratio);
  endfunction
  function automatic int lane_w(input int ratio);
    return $clog2(ratio) + 1;
  endfunction
endpackage

// File: rtl/wr_stream_packer_out_stage.sv
// wr_stream_packer_out_stage: one-word holding register feeding the FIFO write port
module wr_stream_packer_out_stage
  import wr_stream_packer_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int LANE_W = 3,
  parameter int CNT_W = 16
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              load,
  input  logic [OUT_W-1:0]  load_data,
  input  logic [LANE_W-1:0] load_lanes,
  input  logic              fifo_full,
  output logic              out_valid,
  output logic              fifo_wen,
  output logic [OUT_W-1:0]  fifo_wdata,
  output logic [LANE_W-1:0] last_lanes,
  output logic [CNT_W-1:0]  word_cnt
);
  assign fifo_wen = out_valid && !fifo_full;
  // a load may coincide with a drain, which keeps out_valid high with no bubble
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      out_valid  <= 1'b0;
      fifo_wdata <= '0;
      last_lanes <= '0;
      word_cnt   <= '0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        fifo_wdata <= load_data;
        last_lanes <= load_lanes;
      end else if (fifo_wen) begin
        out_valid <= 1'b0;
      end
      word_cnt <= word_cnt + CNT_W'(fifo_wen);
    end
  end
endmodule

// File: rtl/wr_stream_packer.sv
// wr_stream_packer: packs RATIO narrow beats into one FIFO word, s_last closes a word early
module wr_stream_packer
  import wr_stream_packer_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int RATIO = RATIO_DEF,
  parameter int CNT_W = 16,
  localparam int OUT_W = out_w(IN_W, RATIO),
  localparam int IDX_W = idx_w(RATIO),
  localparam int LANE_W = lane_w(RATIO)
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_last,
  input  logic              fifo_full,
  output logic              fifo_wen,
  output logic [OUT_W-1:0]  fifo_wdata,
  output logic [LANE_W-1:0] last_lanes,
  output logic [CNT_W-1:0]  word_cnt
);
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  word;
  logic [IDX_W-1:0]  beat_cnt;
  logic [LANE_W-1:0] lanes;
  logic              out_valid;
  logic              accept;
  logic              complete;
  assign s_ready  = !out_valid || !fifo_full;
  assign accept   = s_valid && s_ready;
  assign complete = accept && (s_last || beat_cnt == IDX_W'(RATIO - 1));
  // acc lanes at and above beat_cnt are always zero, so OR-ing in the beat zero-fills the rest
  assign word     = acc | (OUT_W'(s_data) << (beat_cnt * IN_W));
  assign lanes    = LANE_W'(beat_cnt) + 1'b1;
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
    end else if (complete) begin
      acc      <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      acc      <= word;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
  wr_stream_packer_out_stage #(
    .OUT_W (OUT_W),
    .LANE_W(LANE_W),
    .CNT_W (CNT_W)
  ) u_out (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .load      (complete),
    .load_data (word),
    .load_lanes(lanes),
    .fifo_full (fifo_full),
    .out_valid (out_valid),
    .fifo_wen  (fifo_wen),
    .fifo_wdata(fifo_wdata),
    .last_lanes(last_lanes),
    .word_cnt  (word_cnt)
  );
endmodule

// File: tb/tb_wr_stream_packer.sv
// tb_wr_stream_packer: randomized and directed checks against a word-queue reference model
module tb_wr_stream_packer;
  localparam int IN_W = 2;
  localparam int RATIO = 4;
  localparam int CNT_W = 4;
  localparam int OUT_W = IN_W * RATIO;
  logic             wclk = 1'b0;
  logic             wrst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [IN_W-1:0]  s_data = '0;
  logic             s_last = 1'b0;
  logic             fifo_full = 1'b0;
  logic             fifo_wen;
  logic [OUT_W-1:0] fifo_wdata;
  logic [2:0]       last_lanes;
  logic [CNT_W-1:0] word_cnt;
  int n_vec = 0;
  int n_err = 0;
  logic [OUT_W-1:0] exp_d[$];
  int               exp_l[$];
  logic [IN_W-1:0]  beats[$];
  int               writes = 0;
  bit               accepted = 1'b1;
  wr_stream_packer #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .fifo_full(fifo_full), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .last_lanes(last_lanes), .word_cnt(word_cnt)
  );
  always #5 wclk = ~wclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    exp_d.delete();
    exp_l.delete();
    beats.delete();
    writes = 0;
  endtask
  // called just after a falling edge with inputs already driven for the coming rising edge
  task automatic tick();
    bit wen_e, rdy_e, acc_e;
    logic [OUT_W-1:0] w;
    #1;
    rdy_e = exp_d.size() == 0 || !fifo_full;
    wen_e = exp_d.size() != 0 && !fifo_full;
    chk("s_ready", s_ready, rdy_e);
    chk("fifo_wen", fifo_wen, wen_e);
    if (wen_e) begin
      chk("fifo_wdata", fifo_wdata, exp_d[0]);
      chk("last_lanes", last_lanes, exp_l[0]);
    end
    chk("word_cnt", word_cnt, writes % (1 << CNT_W));
    acc_e = s_valid && rdy_e;
    accepted = acc_e;
    @(posedge wclk);
    if (wen_e) begin
      void'(exp_d.pop_front());
      void'(exp_l.pop_front());
      writes++;
    end
    if (acc_e) begin
      beats.push_back(s_data);
      if (s_last || beats.size() == RATIO) begin
        w = '0;
        foreach (beats[i]) w = w + (OUT_W'(beats[i]) << (i * IN_W));
        exp_d.push_back(w);
        exp_l.push_back(beats.size());
        beats.delete();
      end
    end
    @(negedge wclk);
  endtask
  task automatic send(input logic [IN_W-1:0] d, input bit last);
    int n;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    n = 0;
    do begin
      tick();
      n++;
    end while (!accepted && n < 50);
    if (!accepted) chk("send_timeout", 0, 1);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    fifo_full = 1'b0;
    #1;
    model_clear();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fifo_wen", fifo_wen, 0);
    chk("rst_fifo_wdata", fifo_wdata, 0);
    chk("rst_last_lanes", last_lanes, 0);
    chk("rst_word_cnt", word_cnt, 0);
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    // straight packing: 1,2,3,0 -> 8'h39
    send(2'd1, 0); send(2'd2, 0); send(2'd3, 0); send(2'd0, 0);
    #1;
    chk("pack_39", fifo_wdata, 8'h39);
    chk("pack_lanes", last_lanes, 4);
    tick();
    chk("pack_cnt", word_cnt, 1);
    // partial packet: 3,1 with s_last -> 8'h07, then a fresh word from lane 0
    send(2'd3, 0); send(2'd1, 1);
    #1;
    chk("part_07", fifo_wdata, 8'h07);
    chk("part_lanes", last_lanes, 2);
    tick();
    send(2'd2, 1);
    #1;
    chk("beat0_last", fifo_wdata, 8'h02);
    chk("beat0_lanes", last_lanes, 1);
    tick();
    // backpressure with a constant beat pattern
    fifo_full = 1'b1;
    s_valid = 1'b1;
    s_data = 2'b10;
    repeat (12) tick();
    chk("bp_ready_low", s_ready, 0);
    chk("bp_held", fifo_wdata, 8'hAA);
    chk("bp_no_wen", fifo_wen, 0);
    fifo_full = 1'b0;
    repeat (12) tick();
    s_valid = 1'b0;
    repeat (3) tick();
    // back-to-back streaming
    s_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      s_data = IN_W'($urandom);
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    // reset mid-packet discards the partial word
    send(2'd3, 0); send(2'd3, 0);
    do_reset();
    send(2'd1, 0); send(2'd0, 0); send(2'd1, 0); send(2'd2, 0);
    #1;
    chk("post_rst_word", fifo_wdata, 8'h91);
    tick();
    chk("post_rst_cnt", word_cnt, 1);
    // randomized traffic with legal handshakes; word_cnt wraps along the way
    for (int i = 0; i < 3000; i++) begin
      if (!(s_valid && !accepted)) begin
        s_valid = ($urandom % 4) != 0;
        s_data = IN_W'($urandom);
        s_last = ($urandom % 5) == 0;
      end
      fifo_full = ($urandom % 3) == 0;
      tick();
    end
    s_valid = 1'b0;
    fifo_full = 1'b0;
    repeat (4) tick();
    chk("drained", exp_d.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
